// File: rtl/imem_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : imem_fetch_ctrl
// Brief    : Instruction fetch controller. It owns the PC, reads a
//            combinational instruction memory, and buffers words in a small
//            prefetch queue that feeds decode over a valid/ready handshake.
// Revision : 1.0 - initial release
// ============================================================================
module imem_fetch_ctrl #(
    parameter int          DEPTH     = 2,
    parameter int          MEM_WORDS = 64,
    parameter logic [31:0] RESET_PC  = 32'h0
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rd,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        done
);

    localparam int          c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int          c_CNT_W = $clog2(DEPTH + 1);
    localparam logic [31:0] c_LIMIT = 32'(MEM_WORDS * 4);
    localparam logic [c_CNT_W-1:0] c_DEPTH = c_CNT_W'(DEPTH);

    logic [31:0]        r_pc;
    logic [c_PTR_W-1:0] r_head;
    logic [c_PTR_W-1:0] r_tail;
    logic [c_CNT_W-1:0] r_count;
    logic [31:0]        r_ent_pc   [DEPTH];
    logic [31:0]        r_ent_word [DEPTH];

    logic        w_halted;
    logic        w_pop;
    logic        w_push;
    logic [31:0] w_target;

    assign w_halted = (r_pc >= c_LIMIT);
    assign w_pop    = instr_valid & instr_ready;
    assign w_push   = ~w_halted & ((r_count < c_DEPTH) | w_pop);
    // Masking keeps every redirect_pc bit in use while forcing word alignment.
    assign w_target = redirect_pc & 32'hFFFF_FFFC;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc    <= RESET_PC;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (redirect) begin
            r_pc    <= w_target;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + c_PTR_W'(1);
                r_pc   <= r_pc + 32'd4;
            end
            if (w_pop) begin
                r_head <= r_head + c_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: entries are only observed when count says valid.
    always_ff @(posedge clk) begin
        if (!reset && !redirect && w_push) begin
            r_ent_pc[r_tail]   <= r_pc;
            r_ent_word[r_tail] <= imem_rd;
        end
    end

    assign imem_addr   = r_pc;
    assign instr_valid = (r_count != '0);
    assign instr       = r_ent_word[r_head];
    assign instr_pc    = r_ent_pc[r_head];
    assign done        = w_halted & (r_count == '0);

endmodule
`default_nettype wire

// File: tb/tb_imem_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_imem_fetch_ctrl
// Brief    : Bench for imem_fetch_ctrl: directed scenarios followed by random
//            traffic, compared against a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_imem_fetch_ctrl;

    localparam int          c_DEPTH     = 2;
    localparam int          c_MEM_WORDS = 64;
    localparam logic [31:0] c_RESET_PC  = 32'h0;
    localparam logic [31:0] c_LIMIT     = 32'(c_MEM_WORDS * 4);

    logic        clk;
    logic        reset;
    logic [31:0] imem_addr;
    logic [31:0] imem_rd;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        done;

    logic [31:0] mem [c_MEM_WORDS];

    typedef struct {
        logic [31:0] pc;
        logic [31:0] word;
    } ent_t;

    ent_t        m_q[$];
    logic [31:0] m_pc;
    int          n_checks;
    int          n_fail;

    imem_fetch_ctrl #(
        .DEPTH     (c_DEPTH),
        .MEM_WORDS (c_MEM_WORDS),
        .RESET_PC  (c_RESET_PC)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .imem_addr   (imem_addr),
        .imem_rd     (imem_rd),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        if (addr < c_LIMIT) return mem[addr[7:2]];
        return 32'hDEAD_BEEF;
    endfunction

    always_comb imem_rd = mem_word(imem_addr);

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, compare outputs with the model at the
    // falling edge, advance the model, then return just after the rising edge.
    task automatic cycle(input logic rst, input logic rdy, input logic rdr, input logic [31:0] rpc);
        bit   pop;
        bit   push;
        ent_t e;
        reset       = rst;
        instr_ready = rdy;
        redirect    = rdr;
        redirect_pc = rpc;
        @(negedge clk);
        check_eq("imem_addr", imem_addr, m_pc);
        check_eq("instr_valid", 32'(instr_valid), 32'(m_q.size() != 0));
        check_eq("done", 32'(done), 32'((m_pc >= c_LIMIT) && (m_q.size() == 0)));
        if (m_q.size() != 0) begin
            check_eq("instr", instr, m_q[0].word);
            check_eq("instr_pc", instr_pc, m_q[0].pc);
        end
        if (rst) begin
            m_pc = c_RESET_PC;
            m_q.delete();
        end else if (rdr) begin
            m_pc = {rpc[31:2], 2'b00};
            m_q.delete();
        end else begin
            pop  = (m_q.size() != 0) && rdy;
            push = (m_pc < c_LIMIT) && ((m_q.size() < c_DEPTH) || pop);
            if (pop) void'(m_q.pop_front());
            if (push) begin
                e.pc   = m_pc;
                e.word = mem_word(m_pc);
                m_q.push_back(e);
                m_pc = m_pc + 32'd4;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        m_pc        = c_RESET_PC;
        reset       = 1'b1;
        instr_ready = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        mem[0] = 32'hE3A0_2014;
        mem[1] = 32'hE3A0_4009;
        mem[2] = 32'hE3A0_5008;
        mem[3] = 32'hEC04_9005;
        for (int i = 4; i < c_MEM_WORDS; i++) mem[i] = $urandom;
        @(posedge clk);
        #1;

        // Reset state and streaming with ready held high
        cycle(1'b1, 1'b1, 1'b0, 32'h0);
        check_eq("rst_addr", imem_addr, c_RESET_PC);
        check_eq("rst_valid", 32'(instr_valid), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        cycle(1'b0, 1'b1, 1'b0, 32'h0);
        check_eq("t1_instr0", instr, 32'hE3A0_2014);
        check_eq("t1_pc0", instr_pc, 32'h0);
        cycle(1'b0, 1'b1, 1'b0, 32'h0);
        check_eq("t1_instr1", instr, 32'hE3A0_4009);
        check_eq("t1_pc1", instr_pc, 32'h4);
        cycle(1'b0, 1'b1, 1'b0, 32'h0);
        check_eq("t1_instr2", instr, 32'hE3A0_5008);
        check_eq("t1_pc2", instr_pc, 32'h8);

        // Stall: queue fills and PC freezes, then drains in order
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b0, 32'h0);
        check_eq("t2_addr_frozen", imem_addr, 32'h8);
        check_eq("t2_hold_instr", instr, 32'hE3A0_2014);
        cycle(1'b0, 1'b1, 1'b0, 32'h0);
        check_eq("t2_drain_pc4", instr_pc, 32'h4);
        cycle(1'b0, 1'b1, 1'b0, 32'h0);
        check_eq("t2_drain_pc8", instr_pc, 32'h8);

        // Redirect with a full queue and a misaligned target
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        cycle(1'b0, 1'b0, 1'b1, 32'h0000_000E);
        check_eq("t3_valid", 32'(instr_valid), 32'd0);
        check_eq("t3_addr", imem_addr, 32'hC);
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        check_eq("t3_pc", instr_pc, 32'hC);
        check_eq("t3_instr", instr, 32'hEC04_9005);

        // Running into the fetch limit
        cycle(1'b0, 1'b1, 1'b1, 32'h0000_00F8);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0, 32'h0);
        check_eq("t4_addr_stuck", imem_addr, 32'h100);
        check_eq("t4_done", 32'(done), 32'd1);
        cycle(1'b0, 1'b1, 1'b0, 32'h0);
        check_eq("t4_done_stays", 32'(done), 32'd1);
        check_eq("t4_addr_stays", imem_addr, 32'h100);

        // Redirect beyond the limit, then back into memory
        cycle(1'b0, 1'b1, 1'b1, 32'h0);
        cycle(1'b0, 1'b1, 1'b0, 32'h0);
        cycle(1'b0, 1'b1, 1'b1, 32'h0000_0200);
        check_eq("t5_valid", 32'(instr_valid), 32'd0);
        check_eq("t5_done", 32'(done), 32'd1);
        cycle(1'b0, 1'b1, 1'b1, 32'h0000_0004);
        check_eq("t5_done_low", 32'(done), 32'd0);
        cycle(1'b0, 1'b1, 1'b0, 32'h0);
        check_eq("t5_instr", instr, 32'hE3A0_4009);

        // Reset wins over a simultaneous redirect
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        cycle(1'b1, 1'b0, 1'b1, 32'h0000_0040);
        check_eq("t6_valid", 32'(instr_valid), 32'd0);
        check_eq("t6_addr", imem_addr, c_RESET_PC);

        // Random traffic against the model
        for (int i = 0; i < 600; i++) begin
            logic        rst;
            logic        rdr;
            logic [31:0] rpc;
            rst = ($urandom_range(0, 99) < 2);
            rdr = ($urandom_range(0, 99) < 6);
            rpc = 32'($urandom_range(0, 32'h120));
            cycle(rst, ($urandom_range(0, 99) < 65), rdr, rpc);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
